btn_conditioner: RTL and testbench

Debounces and edge-detects the board push-buttons before they reach the operand-entry and display-select logic of the multiplier top level. Each raw button input is synchronised into the `clk` domain, filtered with a per-channel stability counter, and presented three ways: a clean level, a one-cycle press pulse and a one-cycle release pulse. The block sits between the `btn[4:0]` pins and the top-level control logic, so `reset`/`show_*` decoding always sees glitch-free signals.

---
 rtl/btn_conditioner_if.sv | 28 ++
 rtl/btn_conditioner.sv | 71 +++++++
 tb/tb_btn_conditioner.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/btn_conditioner_if.sv
// Button conditioner bus: raw pins in, debounced level and edge pulses out.
interface btn_conditioner_if #(
    parameter int unsigned N_BTN = 5
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic             any_press;

    // Driver of the raw pins, consumer of the conditioned outputs.
    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  any_press
    );

    // The conditioner itself.
    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release,
        output any_press
    );
endinterface

// File: rtl/btn_conditioner.sv
// Per-channel synchroniser, stability-counter debouncer and press/release edge detector.
module btn_conditioner #(
    parameter int unsigned N_BTN           = 5,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              rst,
    btn_conditioner_if.slave  bus
);
    localparam int unsigned     CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_BTN-1:0] s1_q;
    logic [N_BTN-1:0] s2_q;
    logic [N_BTN-1:0] level_q,   level_d;
    logic [N_BTN-1:0] press_q,   press_d;
    logic [N_BTN-1:0] release_q, release_d;
    logic             any_q,     any_d;
    logic [CNT_W-1:0] cnt_q [N_BTN];
    logic [CNT_W-1:0] cnt_d [N_BTN];

    // Acceptance rule: a level change is taken only after DEBOUNCE_CYCLES consecutive mismatching samples.
    always_comb begin
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        for (int unsigned i = 0; i < N_BTN; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    level_d[i]   = s2_q[i];
                    press_d[i]   = s2_q[i];
                    release_d[i] = ~s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        any_d = |press_d;
    end

    // Synchroniser, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q      <= '0;
            s2_q      <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            any_q     <= 1'b0;
            for (int unsigned i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q      <= bus.btn_raw;
            s2_q      <= s1_q;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            any_q     <= any_d;
            for (int unsigned i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bus.btn_level   = level_q;
    assign bus.btn_press   = press_q;
    assign bus.btn_release = release_q;
    assign bus.any_press   = any_q;
endmodule

// File: tb/tb_btn_conditioner.sv
// Testbench for btn_conditioner: directed scenarios plus random stimulus against a windowed reference model.
module tb_btn_conditioner;
    localparam int unsigned N = 5;
    localparam int unsigned D = 4;

    logic clk;
    logic rst;
    btn_conditioner_if #(.N_BTN(N)) bus ();

    btn_conditioner #(.N_BTN(N), .DEBOUNCE_CYCLES(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int pcount [N];
    int rcount [N];
    bit chk_en  = 1'b0;

    // Reference model: a channel flips when its last D synchronised samples all disagree with its level.
    logic [N-1:0] m_s1, m_s2, m_lvl, m_prs, m_rel;
    logic         m_any;
    logic [N-1:0] m_win [D];

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_s1 = '0; m_s2 = '0; m_lvl = '0; m_prs = '0; m_rel = '0; m_any = 1'b0;
                for (int j = 0; j < int'(D); j++) m_win[j] = '0;
            end else begin
                for (int j = int'(D) - 1; j > 0; j--) m_win[j] = m_win[j-1];
                m_win[0] = m_s2;
                m_prs = '0;
                m_rel = '0;
                for (int i = 0; i < int'(N); i++) begin
                    bit all_diff;
                    all_diff = 1'b1;
                    for (int j = 0; j < int'(D); j++)
                        if (m_win[j][i] == m_lvl[i]) all_diff = 1'b0;
                    if (all_diff) begin
                        m_lvl[i] = ~m_lvl[i];
                        m_prs[i] = m_lvl[i];
                        m_rel[i] = ~m_lvl[i];
                    end
                end
                m_any = |m_prs;
                m_s2  = m_s1;
                m_s1  = bus.btn_raw;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle: compare DUT against the model and tally pulses per channel.
    initial begin
        for (int i = 0; i < int'(N); i++) begin pcount[i] = 0; rcount[i] = 0; end
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("level",   32'(bus.btn_level),   32'(m_lvl));
                check("press",   32'(bus.btn_press),   32'(m_prs));
                check("release", 32'(bus.btn_release), 32'(m_rel));
                check("any",     32'(bus.any_press),   32'(m_any));
                for (int i = 0; i < int'(N); i++) begin
                    pcount[i] += int'(bus.btn_press[i]);
                    rcount[i] += int'(bus.btn_release[i]);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    int snap;
    int hold [N];

    initial begin
        rst = 1'b1;
        bus.btn_raw = 5'b11111;
        @(posedge clk);
        chk_en = 1'b1;
        tick(3);
        // Reset values with all buttons held.
        check("rst_level", 32'(bus.btn_level), 32'h0);
        check("rst_press", 32'(bus.btn_press), 32'h0);
        rst = 1'b0;
        tick(5);
        check("held_press_early", 32'(bus.btn_press), 32'h0);
        tick(1);
        check("held_press",  32'(bus.btn_press), 32'h1f);
        check("held_level",  32'(bus.btn_level), 32'h1f);
        tick(1);
        check("held_press_end", 32'(bus.btn_press), 32'h0);

        // Release everything, then clean press and release on channel 0.
        bus.btn_raw = '0;
        tick(10);
        check("all_released", 32'(bus.btn_level), 32'h0);
        snap = pcount[0];
        bus.btn_raw[0] = 1'b1;
        tick(5);
        check("p0_early", 32'(bus.btn_press), 32'h0);
        tick(1);
        check("p0_pulse", 32'(bus.btn_press), 32'h1);
        check("p0_level", 32'(bus.btn_level), 32'h1);
        tick(14);
        bus.btn_raw[0] = 1'b0;
        tick(5);
        check("r0_early", 32'(bus.btn_release), 32'h0);
        tick(1);
        check("r0_pulse", 32'(bus.btn_release), 32'h1);
        tick(1);
        check("r0_end",   32'(bus.btn_release), 32'h0);
        check("p0_once",  32'(pcount[0] - snap), 32'd1);

        // Bounce on channel 2: never four stable samples.
        snap = pcount[2];
        for (int r = 0; r < 4; r++) begin
            for (int p = 0; p < 4; p++) begin
                bus.btn_raw[2] = (p != 3);
                tick(1);
            end
        end
        tick(2);
        check("bounce_level", 32'(bus.btn_level[2]), 32'h0);
        check("bounce_nopulse", 32'(pcount[2] - snap), 32'd0);
        bus.btn_raw[2] = 1'b1;
        tick(3);
        bus.btn_raw[2] = 1'b0;
        tick(1);
        bus.btn_raw[2] = 1'b1;
        tick(5);
        check("bounce_p_early", 32'(bus.btn_press[2]), 32'h0);
        tick(1);
        check("bounce_press", 32'(bus.btn_press[2]), 32'h1);

        // Glitch while channel 3 is held.
        bus.btn_raw[3] = 1'b1;
        tick(8);
        check("g3_level", 32'(bus.btn_level[3]), 32'h1);
        snap = rcount[3];
        bus.btn_raw[3] = 1'b0;
        tick(3);
        bus.btn_raw[3] = 1'b1;
        tick(10);
        check("g3_hold", 32'(bus.btn_level[3]), 32'h1);
        check("g3_norel", 32'(rcount[3] - snap), 32'd0);

        // Simultaneous press on channels 1 and 4.
        bus.btn_raw[1] = 1'b1;
        bus.btn_raw[4] = 1'b1;
        tick(5);
        check("sim_any_early", 32'(bus.any_press), 32'h0);
        tick(1);
        check("sim_press", 32'(bus.btn_press), 32'h12);
        check("sim_any",   32'(bus.any_press), 32'h1);
        tick(1);
        check("sim_any_end", 32'(bus.any_press), 32'h0);

        // Reset during a count discards it; a fresh press follows the reset.
        bus.btn_raw = '0;
        tick(10);
        bus.btn_raw[0] = 1'b1;
        tick(2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(3);
        check("mid_rst_nopulse", 32'(bus.btn_press), 32'h0);
        tick(2);
        check("mid_rst_early", 32'(bus.btn_press), 32'h0);
        tick(1);
        check("mid_rst_press", 32'(bus.btn_press), 32'h1);

        // Random phase: mixed short glitches and long holds, occasional reset.
        for (int i = 0; i < int'(N); i++) hold[i] = int'($urandom_range(1, 10));
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < int'(N); i++) begin
                hold[i]--;
                if (hold[i] <= 0) begin
                    bus.btn_raw[i] = ~bus.btn_raw[i];
                    hold[i] = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 4))
                                                          : int'($urandom_range(5, 14));
                end
            end
            rst = ($urandom_range(0, 399) == 0);
            tick(1);
        end
        rst = 1'b0;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
